// File: rtl/mem_stage_pkg.sv
// ============================================================================
// mem_stage_pkg : shared types and encodings for the memory pipeline stage
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    localparam int               DATA_W            = 16;
    localparam int               ADDR_W            = 12;
    localparam int               MEM_DEPTH_DEFAULT = 4096;
    localparam logic [ADDR_W-1:0] SP_RESET_DEFAULT = 12'hFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_LO = 2'd1,
        ST_POP_HI  = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_SEL_ALU   = 2'b00;
    localparam logic [1:0] ADDR_SEL_SP    = 2'b01;
    localparam logic [1:0] ADDR_SEL_SP_P1 = 2'b10;

    localparam logic [1:0] WSRC_RDEST = 2'b00;
    localparam logic [1:0] WSRC_RSRC  = 2'b01;
    localparam logic [1:0] WSRC_PC_P1 = 2'b10;
    localparam logic [1:0] WSRC_PC    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// data_memory : 16-bit data RAM, one synchronous write port, two async reads
// Rev 1.0
// ============================================================================
`default_nettype none

module data_memory
    import mem_stage_pkg::*;
#(
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [AW-1:0]     raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

`default_nettype wire

// File: rtl/memory_stage.sv
// ============================================================================
// memory_stage : MEM pipeline stage with data memory, stack pointer and
//                two-word PC push/pop sequencing into the MEM/WB register
// Rev 1.0
// ============================================================================
`default_nettype none

module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int                MEM_DEPTH = MEM_DEPTH_DEFAULT,
    parameter logic [ADDR_W-1:0] SP_RESET  = SP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] alu_result,
    input  logic [15:0] rdest_data,
    input  logic [15:0] rsrc_data,
    input  logic [15:0] LDM_value,
    input  logic [31:0] PC,
    input  logic [31:0] pc_plus_one,
    input  logic [2:0]  flag_register,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_push,
    input  logic        mem_pop,
    input  logic        pc_choose_memory,
    input  logic        pc_choose_interrupt,
    input  logic        reg_write,
    input  logic        outport_enable,
    input  logic [1:0]  memory_address_select,
    input  logic [1:0]  memory_write_src_select,
    input  logic [1:0]  wb_sel,
    input  logic [2:0]  reg_write_address,
    output logic [15:0] mem_data_out,
    output logic [15:0] alu_result_out,
    output logic [15:0] LDM_value_out,
    output logic [1:0]  wb_sel_out,
    output logic [2:0]  reg_write_address_out,
    output logic        reg_write_out,
    output logic        outport_enable_out,
    output logic [31:0] pc_from_memory,
    output logic        pc_from_memory_valid,
    output logic [2:0]  conditions_from_memory_pop,
    output logic        stall
);

    state_e            state_q;
    logic [ADDR_W-1:0] sp_q;
    logic [2:0]        shadow_q;
    logic [15:0]       pc_lo_q;
    logic              pop_irq_q;

    logic [ADDR_W-1:0] sp_m1, sp_m2, sp_p1, sp_p2;
    logic [ADDR_W-1:0] sel_addr, waddr, raddr_b;
    logic [15:0]       src_word, wdata, rdata_a, rdata_b;
    logic [31:0]       pc_src;
    logic              we;
    logic              do_pc_push, do_pop, do_pc_pop, do_write, do_read;

    assign sp_m1 = sp_q - ADDR_W'(1);
    assign sp_m2 = sp_q - ADDR_W'(2);
    assign sp_p1 = sp_q + ADDR_W'(1);
    assign sp_p2 = sp_q + ADDR_W'(2);

    // Priority among simultaneous requests: push > pop > write > read.
    assign do_pc_push = mem_push & memory_write_src_select[1];
    assign do_pop     = ~mem_push & mem_pop;
    assign do_pc_pop  = do_pop & pc_choose_memory;
    assign do_write   = ~mem_push & ~mem_pop & mem_write;
    assign do_read    = ~mem_push & ~mem_pop & ~mem_write & mem_read;

    assign stall = (state_q == ST_IDLE) & (do_pc_push | do_pc_pop);

    always_comb begin
        src_word = rdest_data;
        pc_src   = PC;
        case (memory_write_src_select)
            WSRC_RDEST: src_word = rdest_data;
            WSRC_RSRC:  src_word = rsrc_data;
            WSRC_PC_P1: src_word = pc_plus_one[15:0];
            default:    src_word = PC[15:0];
        endcase
        if (memory_write_src_select == WSRC_PC_P1) begin
            pc_src = pc_plus_one;
        end
    end

    always_comb begin
        sel_addr = alu_result[ADDR_W-1:0];
        case (memory_address_select)
            ADDR_SEL_SP:    sel_addr = sp_q;
            ADDR_SEL_SP_P1: sel_addr = sp_p1;
            default:        sel_addr = alu_result[ADDR_W-1:0];
        endcase
    end

    // Write-port steering; reset suppresses any write, including an aborted PUSH_LO.
    always_comb begin
        we    = 1'b0;
        waddr = sp_q;
        wdata = src_word;
        case (state_q)
            ST_IDLE: begin
                if (mem_push) begin
                    we    = 1'b1;
                    waddr = sp_q;
                    wdata = do_pc_push ? pc_src[31:16] : src_word;
                end else if (do_write) begin
                    we    = 1'b1;
                    waddr = sel_addr;
                    wdata = src_word;
                end
            end
            ST_PUSH_LO: begin
                we    = 1'b1;
                waddr = sp_m1;
                wdata = pc_lo_q;
            end
            default: begin
                we = 1'b0;
            end
        endcase
        if (reset) begin
            we = 1'b0;
        end
    end

    assign raddr_b = (state_q == ST_POP_HI) ? sp_p2 : sp_p1;

    data_memory #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .we_i      (we),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .raddr_a_i (sel_addr),
        .rdata_a_o (rdata_a),
        .raddr_b_i (raddr_b),
        .rdata_b_o (rdata_b)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q                    <= ST_IDLE;
            sp_q                       <= SP_RESET;
            shadow_q                   <= 3'b000;
            pc_lo_q                    <= 16'h0000;
            pop_irq_q                  <= 1'b0;
            mem_data_out               <= 16'h0000;
            alu_result_out             <= 16'h0000;
            LDM_value_out              <= 16'h0000;
            wb_sel_out                 <= 2'b00;
            reg_write_address_out      <= 3'b000;
            reg_write_out              <= 1'b0;
            outport_enable_out         <= 1'b0;
            pc_from_memory             <= 32'h0000_0000;
            pc_from_memory_valid       <= 1'b0;
            conditions_from_memory_pop <= 3'b000;
        end else begin
            alu_result_out        <= alu_result;
            LDM_value_out         <= LDM_value;
            wb_sel_out            <= wb_sel;
            reg_write_address_out <= reg_write_address;
            reg_write_out         <= reg_write & ~stall;
            outport_enable_out    <= outport_enable & ~stall;
            pc_from_memory_valid  <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (do_pc_push) begin
                        pc_lo_q <= pc_src[15:0];
                        if (pc_choose_interrupt) begin
                            shadow_q <= flag_register;
                        end
                        state_q <= ST_PUSH_LO;
                    end else if (mem_push) begin
                        sp_q <= sp_m1;
                    end else if (do_pc_pop) begin
                        pc_lo_q   <= rdata_b;
                        pop_irq_q <= pc_choose_interrupt;
                        state_q   <= ST_POP_HI;
                    end else if (do_pop) begin
                        mem_data_out <= rdata_b;
                        sp_q         <= sp_p1;
                    end else if (do_read) begin
                        mem_data_out <= rdata_a;
                    end
                end
                ST_PUSH_LO: begin
                    sp_q    <= sp_m2;
                    state_q <= ST_IDLE;
                end
                ST_POP_HI: begin
                    pc_from_memory       <= {rdata_b, pc_lo_q};
                    pc_from_memory_valid <= 1'b1;
                    if (pop_irq_q) begin
                        conditions_from_memory_pop <= shadow_q;
                    end
                    sp_q    <= sp_p2;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// tb_memory_stage : scoreboard bench for memory_stage, directed + random ops
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] alu_result, rdest_data, rsrc_data, LDM_value;
    logic [31:0] PC, pc_plus_one;
    logic [2:0]  flag_register;
    logic        mem_read, mem_write, mem_push, mem_pop;
    logic        pc_choose_memory, pc_choose_interrupt, reg_write, outport_enable;
    logic [1:0]  memory_address_select, memory_write_src_select, wb_sel;
    logic [2:0]  reg_write_address;
    logic [15:0] mem_data_out, alu_result_out, LDM_value_out;
    logic [1:0]  wb_sel_out;
    logic [2:0]  reg_write_address_out;
    logic        reg_write_out, outport_enable_out;
    logic [31:0] pc_from_memory;
    logic        pc_from_memory_valid;
    logic [2:0]  conditions_from_memory_pop;
    logic        stall;

    always #5 clk = ~clk;

    memory_stage dut (
        .clk                        (clk),
        .reset                      (reset),
        .alu_result                 (alu_result),
        .rdest_data                 (rdest_data),
        .rsrc_data                  (rsrc_data),
        .LDM_value                  (LDM_value),
        .PC                         (PC),
        .pc_plus_one                (pc_plus_one),
        .flag_register              (flag_register),
        .mem_read                   (mem_read),
        .mem_write                  (mem_write),
        .mem_push                   (mem_push),
        .mem_pop                    (mem_pop),
        .pc_choose_memory           (pc_choose_memory),
        .pc_choose_interrupt        (pc_choose_interrupt),
        .reg_write                  (reg_write),
        .outport_enable             (outport_enable),
        .memory_address_select      (memory_address_select),
        .memory_write_src_select    (memory_write_src_select),
        .wb_sel                     (wb_sel),
        .reg_write_address          (reg_write_address),
        .mem_data_out               (mem_data_out),
        .alu_result_out             (alu_result_out),
        .LDM_value_out              (LDM_value_out),
        .wb_sel_out                 (wb_sel_out),
        .reg_write_address_out      (reg_write_address_out),
        .reg_write_out              (reg_write_out),
        .outport_enable_out         (outport_enable_out),
        .pc_from_memory             (pc_from_memory),
        .pc_from_memory_valid       (pc_from_memory_valid),
        .conditions_from_memory_pop (conditions_from_memory_pop),
        .stall                      (stall)
    );

    typedef struct {
        logic [15:0] alu, rdest, rsrc, ldm;
        logic [31:0] pc, pcp1;
        logic [2:0]  flags, rwa;
        logic        rd, wr, push, pop, pcm, irq, rw, oe;
        logic [1:0]  asel, wsrc, wb;
    } in_t;

    typedef struct {
        logic        stall;
        logic [15:0] mdo, alu, ldm;
        logic [1:0]  wb;
        logic [2:0]  rwa;
        logic        rw, oe, pcv;
        logic [31:0] pc;
        logic [2:0]  cond;
        logic [11:0] sp;
    } rec_t;

    rec_t        exp_q[$];
    logic [15:0] m_mem [4096];
    logic [11:0] m_sp;
    logic [2:0]  m_shadow, m_cond;
    logic [15:0] m_mdo;
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: stall belongs to the current cycle, registered outputs to the previous one.
    initial begin
        rec_t pend;
        bit   have = 1'b0;
        forever begin
            @(negedge clk);
            if (have) begin
                chk("mem_data_out", 32'(mem_data_out), 32'(pend.mdo));
                chk("alu_result_out", 32'(alu_result_out), 32'(pend.alu));
                chk("LDM_value_out", 32'(LDM_value_out), 32'(pend.ldm));
                chk("wb_sel_out", 32'(wb_sel_out), 32'(pend.wb));
                chk("reg_write_address_out", 32'(reg_write_address_out), 32'(pend.rwa));
                chk("reg_write_out", 32'(reg_write_out), 32'(pend.rw));
                chk("outport_enable_out", 32'(outport_enable_out), 32'(pend.oe));
                chk("pc_valid", 32'(pc_from_memory_valid), 32'(pend.pcv));
                chk("pc_from_memory", pc_from_memory, pend.pc);
                chk("conditions", 32'(conditions_from_memory_pop), 32'(pend.cond));
                chk("sp", 32'(dut.sp_q), 32'(pend.sp));
            end
            if (exp_q.size() > 0) begin
                pend = exp_q.pop_front();
                chk("stall", 32'(stall), 32'(pend.stall));
                have = 1'b1;
            end else begin
                have = 1'b0;
            end
        end
    end

    function automatic in_t nop();
        in_t x;
        x.alu   = 16'($urandom); x.rdest = 16'($urandom);
        x.rsrc  = 16'($urandom); x.ldm   = 16'($urandom);
        x.pc    = $urandom;      x.pcp1  = $urandom;
        x.flags = 3'($urandom);  x.rwa   = 3'($urandom);
        x.wb    = 2'($urandom);  x.rw    = 1'($urandom);
        x.oe    = 1'($urandom);
        x.rd = 0; x.wr = 0; x.push = 0; x.pop = 0; x.pcm = 0; x.irq = 0;
        x.asel = 2'b00; x.wsrc = 2'b00;
        return x;
    endfunction

    function automatic rec_t base(input in_t x);
        rec_t r;
        r.stall = 1'b0; r.mdo = m_mdo; r.alu = x.alu; r.ldm = x.ldm;
        r.wb = x.wb; r.rwa = x.rwa; r.rw = x.rw; r.oe = x.oe;
        r.pcv = 1'b0; r.pc = m_pc; r.cond = m_cond; r.sp = m_sp;
        return r;
    endfunction

    task automatic set_inputs(input in_t x, input logic rst);
        reset = rst;
        alu_result = x.alu; rdest_data = x.rdest; rsrc_data = x.rsrc; LDM_value = x.ldm;
        PC = x.pc; pc_plus_one = x.pcp1; flag_register = x.flags;
        mem_read = x.rd; mem_write = x.wr; mem_push = x.push; mem_pop = x.pop;
        pc_choose_memory = x.pcm; pc_choose_interrupt = x.irq;
        reg_write = x.rw; outport_enable = x.oe;
        memory_address_select = x.asel; memory_write_src_select = x.wsrc;
        wb_sel = x.wb; reg_write_address = x.rwa;
    endtask

    task automatic drive(input in_t x, input logic rst, input rec_t r);
        set_inputs(x, rst);
        exp_q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input in_t x, input int n);
        rec_t r;
        m_sp = 12'hFFF; m_shadow = 3'b000; m_cond = 3'b000; m_mdo = 16'h0; m_pc = 32'h0;
        r = '{default: '0};
        r.sp = 12'hFFF;
        repeat (n) drive(x, 1'b1, r);
    endtask

    // Reference model: one call = one whole instruction, 1 or 2 cycles.
    task automatic issue(input in_t x);
        rec_t        r;
        logic [15:0] w;
        logic [31:0] pcv;
        logic [11:0] a, sp0, spm1, spp1, spp2;
        sp0 = m_sp; spm1 = m_sp - 12'd1; spp1 = m_sp + 12'd1; spp2 = m_sp + 12'd2;
        pcv = (x.wsrc == 2'd2) ? x.pcp1 : x.pc;
        case (x.wsrc)
            2'd0: w = x.rdest;
            2'd1: w = x.rsrc;
            2'd2: w = x.pcp1[15:0];
            default: w = x.pc[15:0];
        endcase
        case (x.asel)
            2'd1: a = sp0;
            2'd2: a = spp1;
            default: a = x.alu[11:0];
        endcase
        if (x.push && x.wsrc[1]) begin
            m_mem[sp0] = pcv[31:16];
            if (x.irq) m_shadow = x.flags;
            r = base(x); r.stall = 1'b1; r.rw = 1'b0; r.oe = 1'b0;
            drive(x, 1'b0, r);
            m_mem[spm1] = pcv[15:0];
            m_sp = m_sp - 12'd2;
            drive(x, 1'b0, base(x));
        end else if (x.push) begin
            m_mem[sp0] = w;
            m_sp = spm1;
            drive(x, 1'b0, base(x));
        end else if (x.pop && x.pcm) begin
            r = base(x); r.stall = 1'b1; r.rw = 1'b0; r.oe = 1'b0;
            drive(x, 1'b0, r);
            m_pc = {m_mem[spp2], m_mem[spp1]};
            if (x.irq) m_cond = m_shadow;
            m_sp = spp2;
            r = base(x); r.pcv = 1'b1;
            drive(x, 1'b0, r);
        end else if (x.pop) begin
            m_mdo = m_mem[spp1];
            m_sp = spp1;
            drive(x, 1'b0, base(x));
        end else begin
            if (x.wr) m_mem[a] = w;
            else if (x.rd) m_mdo = m_mem[a];
            drive(x, 1'b0, base(x));
        end
    endtask

    initial begin
        in_t x;
        rec_t r;
        int depth;
        set_inputs(nop(), 1'b1);
        @(posedge clk);
        #1;
        do_reset(nop(), 2);

        // Word push / pop round trip
        x = nop(); x.push = 1; x.wsrc = 2'd0; x.rdest = 16'hABCD; issue(x);
        x = nop(); x.pop = 1; issue(x);

        // PC push, then read both halves back as words
        x = nop(); x.push = 1; x.wsrc = 2'd2; x.pcp1 = 32'h0001_0020; issue(x);
        x = nop(); x.rd = 1; x.alu = 16'h0FFF; issue(x);
        x = nop(); x.rd = 1; x.alu = 16'h0FFE; issue(x);

        // Interrupt push, flags change, interrupt return restores them
        x = nop(); x.push = 1; x.wsrc = 2'd3; x.pc = 32'hCAFE_1234; x.irq = 1; x.flags = 3'b101; issue(x);
        x = nop(); x.flags = 3'b010; issue(x);
        x = nop(); x.pop = 1; x.pcm = 1; x.irq = 1; x.flags = 3'b010; issue(x);
        issue(nop());
        x = nop(); x.pop = 1; x.pcm = 1; issue(x);

        // Stack pointer wrap in both directions
        x = nop(); x.wr = 1; x.alu = 16'h0000; x.rdest = 16'h5A5A; issue(x);
        x = nop(); x.pop = 1; issue(x);
        x = nop(); x.push = 1; x.rdest = 16'h1234; issue(x);
        x = nop(); x.pop = 1; issue(x);

        // Push+pop together, read+write together
        x = nop(); x.push = 1; x.pop = 1; x.rdest = 16'h7777; issue(x);
        x = nop(); x.rd = 1; x.wr = 1; x.wsrc = 2'd1; x.alu = 16'h0010; x.rsrc = 16'hBEEF; issue(x);
        x = nop(); x.rd = 1; x.alu = 16'h0010; issue(x);

        // Reset landing in PUSH_LO aborts the low-half write
        do_reset(nop(), 1);
        x = nop(); x.push = 1; x.rdest = 16'h1111; issue(x);
        x = nop(); x.push = 1; x.rdest = 16'h2222; issue(x);
        do_reset(nop(), 1);
        x = nop(); x.push = 1; x.wsrc = 2'd2; x.pcp1 = 32'h3333_4444;
        m_mem[m_sp] = 16'h3333;
        r = base(x); r.stall = 1'b1; r.rw = 1'b0; r.oe = 1'b0;
        drive(x, 1'b0, r);
        do_reset(x, 1);
        do_reset(nop(), 1);
        x = nop(); x.rd = 1; x.alu = 16'h0FFE; issue(x);
        x = nop(); x.rd = 1; x.alu = 16'h0FFF; issue(x);

        // Random phase: fill a scratch window, then mixed traffic
        do_reset(nop(), 1);
        for (int i = 0; i < 32; i++) begin
            x = nop(); x.wr = 1; x.rd = 1'($urandom); x.alu = 16'(i);
            x.wsrc = 2'($urandom_range(0, 1)); issue(x);
        end
        depth = 0;
        for (int i = 0; i < 300; i++) begin
            int kind;
            kind = (depth >= 40) ? 2 + 2 * $urandom_range(0, 1) : $urandom_range(0, 7);
            x = nop();
            x.irq = 1'($urandom);
            case (kind)
                0, 1: begin
                    x.push = 1; x.pop = 1'($urandom); x.rd = 1'($urandom); x.wr = 1'($urandom);
                    x.wsrc = 2'($urandom_range(0, 1)); depth += 1;
                end
                2: if (depth >= 1) begin
                    x.pop = 1; x.rd = 1'($urandom); x.wr = 1'($urandom); depth -= 1;
                end
                3: begin
                    x.push = 1; x.pop = 1'($urandom); x.wsrc = 2'($urandom_range(2, 3)); depth += 2;
                end
                4: if (depth >= 2) begin
                    x.pop = 1; x.pcm = 1; depth -= 2;
                end
                5: begin
                    x.wr = 1; x.rd = 1'($urandom); x.wsrc = 2'($urandom_range(0, 1));
                    x.alu = {4'($urandom), 7'd0, 5'($urandom)};
                end
                6: begin
                    x.rd = 1; x.alu = {4'($urandom), 7'd0, 5'($urandom)};
                    if (depth >= 1 && $urandom_range(0, 1) == 1) x.asel = 2'd2;
                end
                default: ;
            endcase
            issue(x);
        end
        repeat (3) issue(nop());
        repeat (2) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
